instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Front-end stage that feeds the instruction decoder.
- Keeps the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their addresses in a small prefetch FIFO and presents them to the decoder with a valid/ready handshake.
- Flushes and redirects when the execute stage signals a PC change (branch or write to R15).

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  32  word-aligned read address; stable while mem_req is high.
- mem_ack  in  1  memory returns mem_rdata this cycle; completes the request.
- mem_rdata  in  32  instruction word; sampled only when mem_ack is high.
- ins  out  32  instruction at the FIFO head, to the decoder's ins input.
- ins_pc  out  32  address of ins (the decoder/execute stage adds 8 for the R15 read value).
- ins_valid  out  1  FIFO non-empty; ins and ins_pc are meaningful.
- ins_ready  in  1  decoder accepts the head entry this cycle.
- pcchange  in  1  one-cycle redirect pulse from execute.
- pcnew  in  32  redirect target; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; FIFO empty; state = IDLE.
  - mem_req = 0, mem_addr = RESET_PC, ins_valid = 0; ins and ins_pc = 0.
- States: IDLE, WAIT, DRAIN. At most one request is outstanding.
- IDLE:
  - If FIFO has a free slot and pcchange is low, assert mem_req with mem_addr = fetch_pc and go to WAIT.
  - The first request appears in the first cycle after rst_n rises.
- WAIT:
  - mem_req stays high and mem_addr stays constant until mem_ack.
  - On mem_ack, push {mem_rdata, mem_addr}, set fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), and go to IDLE.
  - A new request may start the cycle after the ack, giving 1 request per 2 cycles minimum.
  - mem_ack arriving in the same cycle as the request is legal.
- FIFO:
  - Push and pop in the same cycle are allowed when full; occupancy is unchanged.
  - No request is issued while occupancy equals DEPTH; pop-then-request happens on the following cycle.
  - ins_valid = (count != 0); ins and ins_pc come from the head entry, driven directly from storage (zero latency).
  - Pop when ins_valid & ins_ready; ins_ready while empty is ignored.
- Redirect (pcchange = 1):
  - The FIFO is flushed the same edge; ins_valid = 0 the next cycle.
  - fetch_pc = {pcnew[31:2], 2'b00}.
  - A pop in the same cycle is overridden by the flush.
  - In IDLE: the next cycle issues a request to the new pc.
  - In WAIT without mem_ack: go to DRAIN. mem_req stays high at the old address until mem_ack, the returned data is discarded, then go to IDLE. Requests are never withdrawn.
  - In WAIT with mem_ack the same cycle: the returned data is discarded, fetch_pc is not incremented, go to IDLE.
  - In DRAIN: a second pcchange updates fetch_pc only; the state stays DRAIN.
- Only data from requests issued after the last redirect ever reaches ins.
- Mid-operation reset: the FIFO is cleared, any outstanding request is abandoned, and mem_req drops immediately (async).
- Memory must not ack when mem_req is low. A stray ack in IDLE is ignored.

Test Plan:
- Reset release, mem_ack every cycle following req, ins_ready = 1 → mem_addr sequence 0, 4, 8, C; ins_pc matches; ins = mem_rdata of the same address; no gaps beyond the 1-idle-cycle rule.
- ins_ready = 0, DEPTH = 2 → exactly 2 requests (0, 4), then mem_req stays low. Raise ins_ready → entry 0 pops, request to 8 is issued the next cycle.
- Redirect in IDLE with pcnew = 32'h0000_0103 → FIFO flushed, ins_valid = 0 the next cycle, next mem_addr = 32'h0000_0100.
- Request to 8 outstanding, pcchange with pcnew = 0x40, ack 3 cycles later with 0xDEADBEEF → mem_addr held at 8 until ack, 0xDEADBEEF is never presented, next request is 0x40.
- pcnew = 32'hFFFF_FFFC, ack → next mem_addr = 0, and ins_pc of the following entry = 0.
- rst_n asserted in WAIT with FIFO holding 1 entry → mem_req = 0 and ins_valid = 0 immediately; after release, the first request is to RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read handshake, decoder valid/ready
// stream, and the redirect pulse from execute.
interface instruction_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        pcchange;
    logic [31:0] pcnew;

    // The fetch unit drives requests and the decoder stream.
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output ins,
        output ins_pc,
        output ins_valid,
        input  ins_ready,
        input  pcchange,
        input  pcnew
    );

    // Memory, decoder and execute stage seen from the outside.
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  ins,
        input  ins_pc,
        input  ins_valid,
        output ins_ready,
        output pcchange,
        output pcnew
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding word reads into a prefetch FIFO,
// with flush/redirect on a PC change from execute.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic                clk,
    input logic                rst_n,
    instruction_fetch_if.master bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_target;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          has_room;
    logic          push;
    logic          pop;

    // Redirect targets are forced word-aligned; the low bits are dropped on purpose.
    logic unused_pcnew_lsb;
    assign unused_pcnew_lsb = ^bus.pcnew[1:0];

    assign pc_target = {bus.pcnew[31:2], 2'b00};
    assign has_room  = (count < CW'(DEPTH));
    assign push      = (state == WAIT) && bus.mem_ack && !bus.pcchange;
    assign pop       = (count != '0) && bus.ins_ready && !bus.pcchange;

    // Request sequencer; DRAIN swallows the one reply already in flight at a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.pcchange) begin
                        fetch_pc <= pc_target;
                    end else if (has_room) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= fetch_pc;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                        fetch_pc    <= bus.pcchange ? pc_target : fetch_pc + 32'd4;
                    end else if (bus.pcchange) begin
                        fetch_pc <= pc_target;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.pcchange) begin
                        fetch_pc <= pc_target;
                    end
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    bus.mem_req <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Prefetch FIFO of {word, address}; a redirect flush wins over any pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (bus.pcchange) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= bus.mem_rdata;
                addr_q[wr_ptr] <= bus.mem_addr;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign bus.ins       = data_q[rd_ptr];
    assign bus.ins_pc    = addr_q[rd_ptr];
    assign bus.ins_valid = (count != '0);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized
// run against an in-order expected-PC stream model.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    int   lat_fixed = 0;
    bit   ack_en    = 1'b1;
    bit   use_beef  = 1'b0;
    int   wait_cnt  = 0;
    int   cur_lat   = 0;

    instruction_fetch_if bus();

    instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3 ^ a;
    endfunction

    // Memory responder: acks after cur_lat cycles of mem_req, never when mem_req is low.
    always @(negedge clk) begin
        if (!rst_n || !bus.mem_req) begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
            cur_lat     = (lat_fixed < 0) ? int'($urandom_range(3, 0)) : lat_fixed;
        end else if (ack_en && wait_cnt >= cur_lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = (use_beef && bus.mem_addr == 32'h8) ? 32'hDEAD_BEEF
                                                                : mem_word(bus.mem_addr);
        end else begin
            bus.mem_ack = 1'b0;
            wait_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input bit ready);
        rst_n         = 1'b0;
        bus.pcchange  = 1'b0;
        bus.pcnew     = '0;
        bus.ins_ready = ready;
        lat_fixed     = lat;
        ack_en        = 1'b1;
        use_beef      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.pcchange  = 1'b0;
        bus.pcnew     = '0;
        bus.ins_ready = 1'b0;
        tick();
        tick();
        tests++;
        if (bus.mem_req !== 1'b0) begin
            fails++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req);
        end
        tests++;
        if (bus.mem_addr !== RESET_PC) begin
            fails++; $display("FAIL reset_mem_addr: got %h want %h", bus.mem_addr, RESET_PC);
        end
        tests++;
        if (bus.ins_valid !== 1'b0 || bus.ins !== 32'h0 || bus.ins_pc !== 32'h0) begin
            fails++; $display("FAIL reset_ins: valid %b ins %h pc %h want 0/0/0",
                              bus.ins_valid, bus.ins, bus.ins_pc);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== RESET_PC) begin
            fails++; $display("FAIL first_req: req %b addr %h want 1/%h",
                              bus.mem_req, bus.mem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int nacks;
        int last_ack;
        do_reset(0, 1'b1);
        exp_pc   = RESET_PC;
        nacks    = 0;
        last_ack = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.mem_req && bus.mem_ack) begin
                if (nacks < 4) begin
                    tests++;
                    if (bus.mem_addr !== RESET_PC + 32'(4 * nacks)) begin
                        fails++; $display("FAIL stream_addr: got %h want %h",
                                          bus.mem_addr, RESET_PC + 32'(4 * nacks));
                    end
                end
                if (nacks > 0 && nacks < 4) begin
                    tests++;
                    if (c - last_ack != 2) begin
                        fails++; $display("FAIL stream_gap: got %0d cycles want 2", c - last_ack);
                    end
                end
                last_ack = c;
                nacks++;
            end
            if (bus.ins_valid) begin
                tests++;
                if (bus.ins_pc !== exp_pc || bus.ins !== mem_word(exp_pc)) begin
                    fails++; $display("FAIL stream_ins: pc %h ins %h want %h/%h",
                                      bus.ins_pc, bus.ins, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
            end
        end
        tests++;
        if (nacks < 4) begin
            fails++; $display("FAIL stream_count: got %0d acks want >=4", nacks);
        end
    endtask

    task automatic test_backpressure_and_redirect_idle();
        int nreq;
        bit found;
        do_reset(0, 1'b0);
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.mem_req && bus.mem_ack) begin
                if (nreq < 2) begin
                    tests++;
                    if (bus.mem_addr !== RESET_PC + 32'(4 * nreq)) begin
                        fails++; $display("FAIL bp_addr: got %h want %h",
                                          bus.mem_addr, RESET_PC + 32'(4 * nreq));
                    end
                end
                nreq++;
            end
        end
        tests++;
        if (nreq != 2 || bus.mem_req !== 1'b0) begin
            fails++; $display("FAIL bp_full: got %0d reqs req=%b want 2/0", nreq, bus.mem_req);
        end
        tests++;
        if (bus.ins_valid !== 1'b1 || bus.ins_pc !== RESET_PC) begin
            fails++; $display("FAIL bp_head: valid %b pc %h want 1/%h",
                              bus.ins_valid, bus.ins_pc, RESET_PC);
        end
        bus.ins_ready = 1'b1;
        tick();
        bus.ins_ready = 1'b0;
        tests++;
        if (bus.mem_req !== 1'b0 || bus.ins_valid !== 1'b1 || bus.ins_pc !== RESET_PC + 32'd4) begin
            fails++; $display("FAIL bp_pop: req %b valid %b pc %h want 0/1/%h",
                              bus.mem_req, bus.ins_valid, bus.ins_pc, RESET_PC + 32'd4);
        end
        tick();
        tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== RESET_PC + 32'd8) begin
            fails++; $display("FAIL bp_refill: req %b addr %h want 1/%h",
                              bus.mem_req, bus.mem_addr, RESET_PC + 32'd8);
        end
        tick();
        tests++;
        if (bus.mem_req !== 1'b0) begin
            fails++; $display("FAIL bp_full2: req %b want 0", bus.mem_req);
        end
        bus.pcchange = 1'b1;
        bus.pcnew    = 32'h0000_0103;
        tick();
        bus.pcchange = 1'b0;
        tests++;
        if (bus.ins_valid !== 1'b0) begin
            fails++; $display("FAIL idle_flush: valid %b want 0", bus.ins_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (bus.mem_req) found = 1'b1;
            else tick();
        end
        tests++;
        if (!found || bus.mem_addr !== 32'h0000_0100) begin
            fails++; $display("FAIL idle_redirect_addr: found %b addr %h want 1/00000100",
                              found, bus.mem_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (bus.ins_valid) found = 1'b1;
        end
        tests++;
        if (!found || bus.ins_pc !== 32'h0000_0100 || bus.ins !== mem_word(32'h100)) begin
            fails++; $display("FAIL idle_redirect_ins: found %b pc %h ins %h want 1/00000100/%h",
                              found, bus.ins_pc, bus.ins, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_wait();
        bit found;
        do_reset(0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.mem_req && bus.mem_ack && bus.mem_addr == 32'h4) found = 1'b1;
        end
        ack_en = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus.mem_req && bus.mem_addr == 32'h8) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL drain_setup: got no request to 8 want one");
        end
        use_beef     = 1'b1;
        bus.pcchange = 1'b1;
        bus.pcnew    = 32'h0000_0040;
        tick();
        bus.pcchange = 1'b0;
        tests++;
        if (bus.ins_valid !== 1'b0) begin
            fails++; $display("FAIL drain_flush: valid %b want 0", bus.ins_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin
                fails++; $display("FAIL drain_hold: req %b addr %h want 1/00000008",
                                  bus.mem_req, bus.mem_addr);
            end
            if (k < 2) tick();
        end
        ack_en = 1'b1;
        tick();
        tick();
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (bus.mem_req) found = 1'b1;
            else tick();
        end
        tests++;
        if (!found || bus.mem_addr !== 32'h0000_0040) begin
            fails++; $display("FAIL drain_next_addr: found %b addr %h want 1/00000040",
                              found, bus.mem_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (bus.ins_valid) found = 1'b1;
        end
        tests++;
        if (!found || bus.ins_pc !== 32'h40 || bus.ins !== mem_word(32'h40)) begin
            fails++; $display("FAIL drain_ins: found %b pc %h ins %h want 1/00000040/%h",
                              found, bus.ins_pc, bus.ins, mem_word(32'h40));
        end
        use_beef = 1'b0;
    endtask

    task automatic test_wrap();
        bit found;
        logic [31:0] exp_pc;
        int nacks;
        int nvalid;
        do_reset(0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (!bus.mem_req) found = 1'b1;
        end
        bus.pcchange = 1'b1;
        bus.pcnew    = 32'hFFFF_FFFC;
        tick();
        bus.pcchange = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        nacks  = 0;
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.mem_req && bus.mem_ack) begin
                if (nacks < 2) begin
                    tests++;
                    if (bus.mem_addr !== 32'hFFFF_FFFC + 32'(4 * nacks)) begin
                        fails++; $display("FAIL wrap_addr: got %h want %h",
                                          bus.mem_addr, 32'hFFFF_FFFC + 32'(4 * nacks));
                    end
                end
                nacks++;
            end
            if (bus.ins_valid) begin
                tests++;
                if (bus.ins_pc !== exp_pc || bus.ins !== mem_word(exp_pc)) begin
                    fails++; $display("FAIL wrap_ins: pc %h ins %h want %h/%h",
                                      bus.ins_pc, bus.ins, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
                nvalid++;
            end
        end
        tests++;
        if (nvalid < 2) begin
            fails++; $display("FAIL wrap_count: got %0d entries want >=2", nvalid);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset(0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus.ins_valid) found = 1'b1;
        end
        ack_en = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (bus.mem_req) found = 1'b1;
        end
        tests++;
        if (!found || bus.ins_valid !== 1'b1) begin
            fails++; $display("FAIL midrst_setup: req %b valid %b want 1/1", found, bus.ins_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.mem_req !== 1'b0 || bus.ins_valid !== 1'b0) begin
            fails++; $display("FAIL midrst_async: req %b valid %b want 0/0",
                              bus.mem_req, bus.ins_valid);
        end
        ack_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== RESET_PC) begin
            fails++; $display("FAIL midrst_restart: req %b addr %h want 1/%h",
                              bus.mem_req, bus.mem_addr, RESET_PC);
        end
        tick();
        tests++;
        if (bus.ins_valid !== 1'b1 || bus.ins_pc !== RESET_PC) begin
            fails++; $display("FAIL midrst_ins: valid %b pc %h want 1/%h",
                              bus.ins_valid, bus.ins_pc, RESET_PC);
        end
    endtask

    // Random ready/redirect/latency; the model is just "next expected PC in program order".
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        bit prev_req;
        bit prev_ack;
        bit redir_prev;
        int pops;
        do_reset(-1, 1'b0);
        exp_pc     = RESET_PC;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_addr  = '0;
        redir_prev = 1'b0;
        pops       = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (redir_prev) begin
                tests++;
                if (bus.ins_valid !== 1'b0) begin
                    fails++; $display("FAIL rnd_flush: valid %b want 0 at cycle %0d", bus.ins_valid, c);
                end
            end
            if (bus.ins_valid) begin
                tests++;
                if (bus.ins_pc !== exp_pc || bus.ins !== mem_word(exp_pc)) begin
                    fails++; $display("FAIL rnd_ins: pc %h ins %h want %h/%h at cycle %0d",
                                      bus.ins_pc, bus.ins, exp_pc, mem_word(exp_pc), c);
                end
            end
            if (prev_req && !prev_ack && bus.mem_req) begin
                tests++;
                if (bus.mem_addr !== prev_addr) begin
                    fails++; $display("FAIL rnd_addr_stable: got %h want %h", bus.mem_addr, prev_addr);
                end
            end
            prev_req  = bus.mem_req;
            prev_ack  = bus.mem_ack;
            prev_addr = bus.mem_addr;
            bus.ins_ready = ($urandom_range(3, 0) != 0);
            bus.pcchange  = ($urandom_range(31, 0) == 0);
            bus.pcnew     = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                        : 32'($urandom);
            if (bus.pcchange) begin
                exp_pc = {bus.pcnew[31:2], 2'b00};
            end else if (bus.ins_valid && bus.ins_ready) begin
                exp_pc += 32'd4;
                pops++;
            end
            redir_prev = bus.pcchange;
        end
        bus.pcchange = 1'b0;
        tests++;
        if (pops < 100) begin
            fails++; $display("FAIL rnd_progress: got %0d pops want >=100", pops);
        end
    endtask

    initial begin
        bus.ins_ready = 1'b0;
        bus.pcchange  = 1'b0;
        bus.pcnew     = '0;
        test_reset();
        test_stream();
        test_backpressure_and_redirect_idle();
        test_redirect_wait();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
